// File: rtl/ahb_lite_adc_slave_bridge_pkg.sv
// Shared constants for the MAX10 ADC AHB-Lite bridge: register-port width,
// register offsets, AHB transfer encodings and the bridge FSM state type.
package ahb_lite_adc_slave_bridge_pkg;

  localparam int ADC_ADDR_WIDTH = 4;

  localparam int ADC_REG_ADCS  = 0;
  localparam int ADC_REG_ADMSK = 1;
  localparam int ADC_REG_ADC1  = 2;

  localparam logic [1:0] AHB_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] AHB_HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] AHB_HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] AHB_HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] AHB_HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RD_WAIT,
    S_RD_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
  function automatic logic ahb_trans_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahb_lite_adc_slave_bridge.sv
// AHB-Lite slave front end for the MAX10 ADC core register port.
// Define ADC_AHB_ERROR_RESPONSE_EN to answer illegal transfers with a two-cycle ERROR.
module ahb_lite_adc_slave_bridge
  import ahb_lite_adc_slave_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = ADC_ADDR_WIDTH,
  parameter int REG_COUNT  = 2 ** ADDR_WIDTH
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [31:0]           HADDR,
  input  logic                  HSEL,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  input  logic [31:0]           HWDATA,
  output logic [31:0]           HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [31:0]           read_data,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [31:0]           write_data,
  output logic                  write_enable
);

  localparam logic [ADDR_WIDTH:0] REG_LIMIT = (ADDR_WIDTH + 1)'(REG_COUNT);

  state_t                  state_reg;
  logic                    rd_zero_reg;
  logic [ADDR_WIDTH-1:0]   haddr_idx;
  logic                    accept_ok;
  logic                    xfer_start;
  logic                    xfer_legal;
  logic                    unused_inputs;

  assign haddr_idx = HADDR[ADDR_WIDTH+1:2];

  // Final data-phase states double as idle so a pipelined address phase is taken without a bubble.
  assign accept_ok = (state_reg == S_IDLE) || (state_reg == S_WRITE) ||
                     (state_reg == S_RD_DATA) || (state_reg == S_ERR2);

  assign xfer_start = HSEL && HREADY && ahb_trans_active(HTRANS) && accept_ok;
  assign xfer_legal = (HSIZE == AHB_HSIZE_WORD) && ({1'b0, haddr_idx} < REG_LIMIT);

  // The core samples write data during the data phase, so it cannot be registered here.
  assign write_data = write_enable ? HWDATA : 32'h0;

  assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HADDR[31:ADDR_WIDTH+2], HADDR[1:0]};

`ifndef ADC_AHB_ERROR_RESPONSE_EN
  assign HRESP = 1'b0;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg    <= S_IDLE;
      HRDATA       <= 32'h0;
      HREADYOUT    <= 1'b1;
      write_enable <= 1'b0;
      write_addr   <= '0;
      read_addr    <= '0;
      rd_zero_reg  <= 1'b0;
`ifdef ADC_AHB_ERROR_RESPONSE_EN
      HRESP        <= 1'b0;
`endif
    end else begin
      write_enable <= 1'b0;
      case (state_reg)
        S_RD_WAIT: begin
          HRDATA    <= rd_zero_reg ? 32'h0 : read_data;
          HREADYOUT <= 1'b1;
          state_reg <= S_RD_DATA;
        end
`ifdef ADC_AHB_ERROR_RESPONSE_EN
        S_ERR1: begin
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
          state_reg <= S_ERR2;
        end
`endif
        default: begin
          HREADYOUT <= 1'b1;
          state_reg <= S_IDLE;
`ifdef ADC_AHB_ERROR_RESPONSE_EN
          HRESP     <= 1'b0;
          if (xfer_start) begin
            if (!xfer_legal) begin
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b1;
              state_reg <= S_ERR1;
            end else if (HWRITE) begin
              write_enable <= 1'b1;
              write_addr   <= haddr_idx;
              state_reg    <= S_WRITE;
            end else begin
              read_addr   <= haddr_idx;
              rd_zero_reg <= 1'b0;
              HREADYOUT   <= 1'b0;
              state_reg   <= S_RD_WAIT;
            end
          end
`else
          // Illegal writes finish as a plain zero-wait OKAY; illegal reads return zero.
          if (xfer_start) begin
            if (HWRITE) begin
              if (xfer_legal) begin
                write_enable <= 1'b1;
                write_addr   <= haddr_idx;
                state_reg    <= S_WRITE;
              end
            end else begin
              read_addr   <= xfer_legal ? haddr_idx : '0;
              rd_zero_reg <= !xfer_legal;
              HREADYOUT   <= 1'b0;
              state_reg   <= S_RD_WAIT;
            end
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_adc_slave_bridge.sv
// Self-checking bench for ahb_lite_adc_slave_bridge: vector table through a
// scoreboard, plus hand sequences for idle/busy, back-to-back and reset.
module tb_ahb_lite_adc_slave_bridge;
  import ahb_lite_adc_slave_bridge_pkg::*;

  localparam int AW = ADC_ADDR_WIDTH;
  localparam int RC = 12;
`ifdef ADC_AHB_ERROR_RESPONSE_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic [31:0]   HADDR;
  logic          HSEL;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [2:0]    HBURST;
  logic [3:0]    HPROT;
  logic          HMASTLOCK;
  logic          HREADY;
  logic [31:0]   HWDATA;
  logic [31:0]   HRDATA;
  logic          HREADYOUT;
  logic          HRESP;
  logic [AW-1:0] read_addr;
  logic [31:0]   read_data;
  logic [AW-1:0] write_addr;
  logic [31:0]   write_data;
  logic          write_enable;

  assign HREADY = HREADYOUT;

  always #5 HCLK = ~HCLK;

  ahb_lite_adc_slave_bridge #(.ADDR_WIDTH(AW), .REG_COUNT(RC)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HSEL(HSEL), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .read_addr(read_addr),
    .read_data(read_data), .write_addr(write_addr), .write_data(write_data),
    .write_enable(write_enable)
  );

  // Core register file stand-in: reset pattern A000_00nn, synchronous write, combinational read.
  logic [31:0] core_regs [0:(1<<AW)-1];
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < (1 << AW); i++) core_regs[i] <= 32'hA000_0000 + 32'(i);
    end else if (write_enable) begin
      core_regs[write_addr] <= write_data;
    end
  end
  assign read_data = core_regs[read_addr];

  typedef struct {
    int          id;
    logic        wr;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          exp_waits;
    logic        exp_resp;
    logic        exp_we;
    logic        chk_rd;
    logic [31:0] exp_rdata;
  } xfer_t;

  int    checks = 0;
  int    failures = 0;
  xfer_t sb_q[$];
  xfer_t vec[14];

  function automatic void check(string name, int id, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s id=%0d actual=%h expected=%h", name, id, act, exp);
    end
  endfunction

  function automatic xfer_t mk(int id, logic wr, logic [31:0] addr, logic [2:0] size,
                               logic [31:0] wdata, int waits, logic resp, logic we,
                               logic chk_rd, logic [31:0] rdata);
    xfer_t x;
    x.id = id; x.wr = wr; x.trans = AHB_HTRANS_NONSEQ; x.addr = addr; x.size = size;
    x.wdata = wdata; x.exp_waits = waits; x.exp_resp = resp; x.exp_we = we;
    x.chk_rd = chk_rd; x.exp_rdata = rdata;
    return x;
  endfunction

  // Presents one address phase, waits (bounded) until it is taken, then queues its expectation.
  task automatic drive(input xfer_t x, output int stalls);
    HSEL = 1'b1; HTRANS = x.trans; HADDR = x.addr; HWRITE = x.wr; HSIZE = x.size;
    stalls = 0;
    @(negedge HCLK);
    while (!HREADYOUT && stalls < 20) begin
      stalls++;
      @(negedge HCLK);
    end
    if (!HREADYOUT) begin
      checks++; failures++;
      $display("FAIL accept_timeout id=%0d actual=stalled expected=ready", x.id);
    end
    @(posedge HCLK); #1;
    sb_q.push_back(x);
    if (x.wr) HWDATA = x.wdata;
  endtask

  task automatic bus_idle(input int n, input logic [1:0] tr, input logic sel);
    HSEL = sel; HTRANS = tr;
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  // Monitor: follows each data phase and compares it against the scoreboard head on completion.
  bit          dp_valid = 1'b0;
  bit          dp_first = 1'b1;
  int          dp_waits = 0;
  int          dp_we_cnt = 0;
  logic        dp_resp_first = 1'b0;
  initial begin
    xfer_t cur;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        dp_valid = 1'b0; dp_first = 1'b1; dp_waits = 0; dp_we_cnt = 0;
        sb_q.delete();
      end else begin
        if (dp_valid && sb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_underflow id=-1 actual=empty expected=entry");
          dp_valid = 1'b0;
        end
        if (dp_valid) begin
          cur = sb_q[0];
          if (dp_first) begin
            dp_resp_first = HRESP;
            dp_first = 1'b0;
          end
          if (write_enable) begin
            dp_we_cnt++;
            check("we_addr", cur.id, 32'(write_addr), 32'(cur.addr[AW+1:2]));
            check("we_data", cur.id, write_data, cur.wdata);
          end
          if (!HREADYOUT) begin
            dp_waits++;
          end else begin
            void'(sb_q.pop_front());
            check("waits", cur.id, dp_waits, cur.exp_waits);
            check("resp_first", cur.id, 32'(dp_resp_first), 32'(cur.exp_resp));
            check("resp", cur.id, 32'(HRESP), 32'(cur.exp_resp));
            check("we_count", cur.id, dp_we_cnt, 32'(cur.exp_we));
            if (cur.chk_rd) check("rdata", cur.id, HRDATA, cur.exp_rdata);
            $display("xfer id=%0d %s addr=%h size=%0d waits=%0d resp=%0d we=%0d rdata=%h",
                     cur.id, cur.wr ? "WR" : "RD", cur.addr, cur.size, dp_waits,
                     dp_resp_first, dp_we_cnt, HRDATA);
            dp_first = 1'b1; dp_waits = 0; dp_we_cnt = 0;
          end
        end else begin
          check("idle_we", -1, 32'(write_enable), 32'h0);
          check("idle_ready", -1, 32'(HREADYOUT), 32'h1);
          check("idle_resp", -1, 32'(HRESP), 32'h0);
        end
        if (!dp_valid || HREADYOUT) dp_valid = HSEL && HTRANS[1] && HREADYOUT;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st;
    xfer_t x;
    HRESETn = 1'b0; HSEL = 1'b0; HTRANS = AHB_HTRANS_IDLE; HADDR = 32'h0; HWRITE = 1'b0;
    HSIZE = AHB_HSIZE_WORD; HBURST = 3'b000; HPROT = 4'b0011; HMASTLOCK = 1'b0;
    HWDATA = 32'hFFFF_FFFF;

    repeat (3) @(negedge HCLK);
    check("rst_hrdata", 0, HRDATA, 32'h0);
    check("rst_ready", 0, 32'(HREADYOUT), 32'h1);
    check("rst_resp", 0, 32'(HRESP), 32'h0);
    check("rst_we", 0, 32'(write_enable), 32'h0);
    check("rst_waddr", 0, 32'(write_addr), 32'h0);
    check("rst_wdata", 0, write_data, 32'h0);
    check("rst_raddr", 0, 32'(read_addr), 32'h0);
    #1 HRESETn = 1'b1;
    @(posedge HCLK); #1;

    vec[0]  = mk(0, 1'b1, 32'(ADC_REG_ADMSK * 4), AHB_HSIZE_WORD, 32'h0000_0002, 0, 1'b0, 1'b1, 1'b0, 32'h0);
    vec[1]  = mk(1, 1'b0, 32'(ADC_REG_ADMSK * 4), AHB_HSIZE_WORD, 32'h0, 1, 1'b0, 1'b0, 1'b1, 32'h0000_0002);
    vec[2]  = mk(2, 1'b0, 32'h14, AHB_HSIZE_WORD, 32'h0, 1, 1'b0, 1'b0, 1'b1, 32'hA000_0005);
    vec[3]  = mk(3, 1'b1, 32'h1C, AHB_HSIZE_WORD, 32'hDEAD_BEEF, 0, 1'b0, 1'b1, 1'b0, 32'h0);
    vec[4]  = mk(4, 1'b0, 32'h1C, AHB_HSIZE_WORD, 32'h0, 1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    vec[4].trans = AHB_HTRANS_SEQ;
    vec[5]  = mk(5, 1'b1, 32'h2C, AHB_HSIZE_WORD, 32'h1234_5678, 0, 1'b0, 1'b1, 1'b0, 32'h0);
    vec[6]  = mk(6, 1'b0, 32'h2C, AHB_HSIZE_WORD, 32'h0, 1, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
    vec[7]  = mk(7, 1'b0, 32'(RC * 4), AHB_HSIZE_WORD, 32'h0, 1, ERR_EN, 1'b0, !ERR_EN, 32'h0);
    vec[8]  = mk(8, 1'b1, 32'h0C, 3'b000, 32'h0000_0055, ERR_EN ? 1 : 0, ERR_EN, 1'b0, 1'b0, 32'h0);
    vec[9]  = mk(9, 1'b0, 32'h0C, AHB_HSIZE_WORD, 32'h0, 1, 1'b0, 1'b0, 1'b1, 32'hA000_0003);
    vec[10] = mk(10, 1'b0, 32'h08, 3'b001, 32'h0, 1, ERR_EN, 1'b0, !ERR_EN, 32'h0);
    vec[11] = mk(11, 1'b1, 32'(RC * 4), AHB_HSIZE_WORD, 32'h0000_0077, ERR_EN ? 1 : 0, ERR_EN, 1'b0, 1'b0, 32'h0);
    vec[12] = mk(12, 1'b0, 32'(ADC_REG_ADCS * 4), AHB_HSIZE_WORD, 32'h0, 1, 1'b0, 1'b0, 1'b1, 32'hA000_0000);
    vec[13] = mk(13, 1'b0, 32'h8000_0018, AHB_HSIZE_WORD, 32'h0, 1, 1'b0, 1'b0, 1'b1, 32'hA000_0006);

    for (int i = 0; i < 14; i++) drive(vec[i], st);
    bus_idle(4, AHB_HTRANS_IDLE, 1'b0);

    // IDLE and BUSY while selected must not start anything.
    bus_idle(3, AHB_HTRANS_IDLE, 1'b1);
    bus_idle(3, AHB_HTRANS_BUSY, 1'b1);
    @(negedge HCLK);
    check("busy_we", 20, 32'(write_enable), 32'h0);
    check("busy_ready", 20, 32'(HREADYOUT), 32'h1);
    check("busy_resp", 20, 32'(HRESP), 32'h0);
    @(posedge HCLK); #1;

    // Back-to-back write then read of ADCS, read address phase taken with no bubble.
    x = mk(21, 1'b1, 32'(ADC_REG_ADCS * 4), AHB_HSIZE_WORD, 32'h0000_000F, 0, 1'b0, 1'b1, 1'b0, 32'h0);
    drive(x, st);
    x = mk(22, 1'b0, 32'(ADC_REG_ADCS * 4), AHB_HSIZE_WORD, 32'h0, 1, 1'b0, 1'b0, 1'b1, 32'h0000_000F);
    drive(x, st);
    check("no_bubble", 22, st, 0);
    bus_idle(4, AHB_HTRANS_IDLE, 1'b0);

    // Reset asserted while a read is in its wait state.
    x = mk(23, 1'b0, 32'h14, AHB_HSIZE_WORD, 32'h0, 1, 1'b0, 1'b0, 1'b1, 32'hA000_0005);
    drive(x, st);
    x = mk(24, 1'b0, 32'h1C, AHB_HSIZE_WORD, 32'h0, 1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    drive(x, st);
    HSEL = 1'b0; HTRANS = AHB_HTRANS_IDLE;
    @(negedge HCLK); #1;
    HRESETn = 1'b0;
    #1;
    check("midrst_ready", 24, 32'(HREADYOUT), 32'h1);
    check("midrst_hrdata", 24, HRDATA, 32'h0);
    check("midrst_raddr", 24, 32'(read_addr), 32'h0);
    check("midrst_resp", 24, 32'(HRESP), 32'h0);
    @(negedge HCLK); #1;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    x = mk(25, 1'b0, 32'(ADC_REG_ADMSK * 4), AHB_HSIZE_WORD, 32'h0, 1, 1'b0, 1'b0, 1'b1, 32'hA000_0001);
    drive(x, st);
    x = mk(26, 1'b1, 32'(ADC_REG_ADC1 * 4), AHB_HSIZE_WORD, 32'hCAFE_0123, 0, 1'b0, 1'b1, 1'b0, 32'h0);
    drive(x, st);
    x = mk(27, 1'b0, 32'(ADC_REG_ADC1 * 4), AHB_HSIZE_WORD, 32'h0, 1, 1'b0, 1'b0, 1'b1, 32'hCAFE_0123);
    drive(x, st);
    bus_idle(6, AHB_HTRANS_IDLE, 1'b0);

    check("sb_drain", 99, 32'(sb_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
